// File: rtl/riscv_pkg.sv
// Shared IITB-RISC constants and the LM/SM sequencer state encoding.
package riscv_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned REG_AW = 3;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } seq_state_t;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// Priority encoder: index of the lowest set bit (bit 0 wins) plus a valid flag.
module lowest_set_bit_enc #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top down so the lowest set bit is the last one to assign.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register mask in ascending
// order and performs one memory transfer per selected register.
module lm_sm_sequencer
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_lm,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   mask,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [REG_AW-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NREG-1:0]   rem_q, rem_d;
    logic              lm_q, lm_d;

    logic [REG_AW-1:0] idx;
    logic              idx_valid;
    logic [NREG-1:0]   rem_clr;

    lowest_set_bit_enc #(
        .N (NREG),
        .W (REG_AW)
    ) u_enc (
        .vec   (rem_q),
        .idx   (idx),
        .valid (idx_valid)
    );

    // State and latched operation parameters; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lm_q    <= lm_d;
        end
    end

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        lm_d       = lm_q;
        rem_clr    = rem_q & ~(NREG'(1) << idx);
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rf_rd_addr = '0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = mask;
                    lm_d    = is_lm;
                    state_d = (mask != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                busy       = 1'b1;
                mem_req    = 1'b1;
                mem_we     = ~lm_q;
                mem_addr   = addr_q;
                rf_rd_addr = idx;
                mem_wdata  = rf_rd_data;
                // Without an ack everything holds, so the request stays stable.
                if (mem_ack && idx_valid) begin
                    if (lm_q) begin
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = idx;
                        rf_wr_data = mem_rdata;
                    end
                    rem_d  = rem_clr;
                    addr_d = addr_q + ADDR_W'(1);
                    if (rem_clr == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench: queue-based transfer model, per-cycle output compare,
// directed scenarios with literal expectations, then randomized operations.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_lm = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  mask = '0;
    logic        busy, done, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;

    logic [15:0] mem_arr [0:65535];
    logic [15:0] rf_arr [0:7];
    logic [15:0] pre_val [0:7];
    logic        pre_en = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    int fixed_wait = 0;
    bit rand_wait = 1'b0;
    bit stray_ack = 1'b0;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] a;
    } xfer_t;
    xfer_t xq[$];
    bit    m_done = 1'b0;
    bit    m_lm = 1'b0;

    assign mem_rdata  = mem_arr[mem_addr];
    assign rf_rd_data = rf_arr[rf_rd_addr];

    lm_sm_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_lm      (is_lm),
        .base_addr  (base_addr),
        .mask       (mask),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Register file and memory: capture write strobes mid-cycle, apply at the edge.
    initial begin
        logic        s_rf_we, s_mem_we;
        logic [2:0]  s_rf_a;
        logic [15:0] s_rf_d, s_mem_a, s_mem_d;
        for (int a = 0; a < 65536; a++) mem_arr[a] = 16'hA000 + 16'(a);
        for (int i = 0; i < 8; i++) rf_arr[i] = '0;
        forever begin
            @(negedge clk);
            s_rf_we  = rf_wr_en;
            s_rf_a   = rf_wr_addr;
            s_rf_d   = rf_wr_data;
            s_mem_we = mem_req & mem_we & mem_ack;
            s_mem_a  = mem_addr;
            s_mem_d  = mem_wdata;
            @(posedge clk);
            if (rst_n) begin
                if (pre_en) begin
                    for (int i = 0; i < 8; i++) rf_arr[i] = pre_val[i];
                end else if (s_rf_we) begin
                    rf_arr[s_rf_a] = s_rf_d;
                end
                if (s_mem_we) mem_arr[s_mem_a] = s_mem_d;
            end
        end
    end

    // Memory responder: per-transfer wait count, optional stray acks while idle.
    initial begin
        int wcnt, wtarget;
        bit pend;
        wcnt = 0; wtarget = 0; pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ack = 1'b0;
                pend    = 1'b0;
            end else begin
                if (mem_ack) pend = 1'b0;
                if (mem_req) begin
                    if (!pend) begin
                        pend    = 1'b1;
                        wcnt    = 0;
                        wtarget = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
                    end
                    if (wcnt >= wtarget) mem_ack = 1'b1;
                    else begin
                        mem_ack = 1'b0;
                        wcnt++;
                    end
                end else begin
                    pend    = 1'b0;
                    mem_ack = stray_ack && ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Reference model: an accepted start expands the mask into an ordered list of
    // (register, address) transfers; each ack retires the head; an empty list
    // is followed by one done cycle.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                xq.delete();
                m_done = 1'b0;
                m_lm   = 1'b0;
            end else if (xq.size() != 0) begin
                if (mem_ack) begin
                    void'(xq.pop_front());
                    if (xq.size() == 0) m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (start) begin
                int k;
                k = 0;
                m_lm = is_lm;
                for (int i = 0; i < 8; i++) begin
                    if (mask[i]) begin
                        xq.push_back('{r: 3'(i), a: base_addr + 16'(k)});
                        k++;
                    end
                end
                if (k == 0) m_done = 1'b1;
            end
        end
    end

    // Compare every DUT output against the model on every falling edge.
    initial begin
        logic        e_busy, e_done, e_req, e_we, e_wen;
        logic [15:0] e_addr, e_wd, e_wdat;
        logic [2:0]  e_rda, e_wa;
        forever begin
            @(negedge clk);
            e_busy = 0; e_done = 0; e_req = 0; e_we = 0; e_wen = 0;
            e_addr = '0; e_wd = '0; e_wdat = '0; e_rda = '0; e_wa = '0;
            if (xq.size() != 0) begin
                e_busy = 1; e_req = 1; e_we = !m_lm;
                e_addr = xq[0].a;
                e_rda  = xq[0].r;
                e_wd   = rf_arr[xq[0].r];
                if (m_lm && mem_ack) begin
                    e_wen  = 1;
                    e_wa   = xq[0].r;
                    e_wdat = mem_arr[xq[0].a];
                end
            end else if (m_done) begin
                e_busy = 1; e_done = 1;
            end
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("mem_req", 32'(mem_req), 32'(e_req));
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            check("rf_rd_addr", 32'(rf_rd_addr), 32'(e_rda));
            check("rf_wr_en", 32'(rf_wr_en), 32'(e_wen));
            check("rf_wr_addr", 32'(rf_wr_addr), 32'(e_wa));
            check("rf_wr_data", 32'(rf_wr_data), 32'(e_wdat));
        end
    end

    task automatic preload(input logic [15:0] base);
        for (int i = 0; i < 8; i++) pre_val[i] = base + 16'(i);
        pre_en = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Issue one operation; lat counts cycles from the start cycle to the done cycle.
    task automatic run_op(input bit lm, input logic [15:0] base, input logic [7:0] msk,
                          input int poke_at, output int lat, output int wr_cnt,
                          output int req_cnt, output int busy_cnt);
        bit poked;
        poked = 1'b0;
        lat = -1; wr_cnt = 0; req_cnt = 0; busy_cnt = 0;
        start = 1'b1; is_lm = lm; base_addr = base; mask = msk;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        is_lm = 1'($urandom); base_addr = 16'($urandom); mask = 8'($urandom);
        for (int idx = 1; idx < 200; idx++) begin
            @(negedge clk);
            if (poked) begin
                start = 1'b0;
                poked = 1'b0;
            end
            if (rf_wr_en) wr_cnt++;
            if (mem_req) req_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                lat = idx;
                break;
            end
            if (idx == poke_at) begin
                start = 1'b1; is_lm = ~lm; mask = 8'hFF; base_addr = 16'h0999;
                poked = 1'b1;
            end
        end
        start = 1'b0;
        if (lat < 0) check("op_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, wr, req, bsy, dn;
        bit lm;
        logic [7:0]  msk;
        logic [15:0] base;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_rf_wr_en", 32'(rf_wr_en), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        preload(16'h5000);

        // LM with zero-wait memory
        fixed_wait = 0;
        run_op(1'b1, 16'h0100, 8'b1000_0101, 0, lat, wr, req, bsy);
        check("lm_lat", 32'(lat), 32'(4));
        check("lm_wr_cnt", 32'(wr), 32'(3));
        check("lm_r0", 32'(rf_arr[0]), 32'h0000_A100);
        check("lm_r2", 32'(rf_arr[2]), 32'h0000_A101);
        check("lm_r7", 32'(rf_arr[7]), 32'h0000_A102);
        check("lm_r1_kept", 32'(rf_arr[1]), 32'h0000_5001);

        // SM of all eight registers
        preload(16'h1110);
        run_op(1'b0, 16'h0020, 8'hFF, 0, lat, wr, req, bsy);
        check("sm_lat", 32'(lat), 32'(9));
        check("sm_wr_cnt", 32'(wr), 32'(0));
        for (int i = 0; i < 8; i++) check("sm_mem", 32'(mem_arr[16'h0020 + i]), 32'(16'h1110 + i));

        // Zero mask
        run_op(1'b1, 16'h0200, 8'h00, 0, lat, wr, req, bsy);
        check("zero_lat", 32'(lat), 32'(1));
        check("zero_req", 32'(req), 32'(0));
        check("zero_busy", 32'(bsy), 32'(1));

        // Wait states with address wrap
        fixed_wait = 3;
        run_op(1'b1, 16'hFFFF, 8'b0000_0011, 0, lat, wr, req, bsy);
        check("wrap_lat", 32'(lat), 32'(9));
        check("wrap_wr_cnt", 32'(wr), 32'(2));
        check("wrap_r0", 32'(rf_arr[0]), 32'h0000_9FFF);
        check("wrap_r1", 32'(rf_arr[1]), 32'h0000_A000);

        // Start pulsed while busy is ignored
        fixed_wait = 1;
        run_op(1'b1, 16'h0040, 8'b0000_1010, 2, lat, wr, req, bsy);
        check("poke_lat", 32'(lat), 32'(5));
        check("poke_wr_cnt", 32'(wr), 32'(2));
        check("poke_req", 32'(req), 32'(4));
        @(negedge clk);
        check("poke_idle_after", 32'(busy), 32'(0));
        @(posedge clk);
        #1;

        // Reset during the second transfer of a four-register LM
        preload(16'h5550);
        fixed_wait = 2;
        start = 1'b1; is_lm = 1'b1; base_addr = 16'h0300; mask = 8'h0F;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wr = 0;
        for (int i = 0; i < 20 && wr == 0; i++) begin
            @(negedge clk);
            if (rf_wr_en) wr = 1;
        end
        check("rst_mid_first_wr", 32'(wr), 32'(1));
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_req", 32'(mem_req), 32'(0));
        check("rst_mid_addr", 32'(mem_addr), 32'(0));
        check("rst_mid_wen", 32'(rf_wr_en), 32'(0));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_mid_no_done", 32'(dn), 32'(0));
        check("rst_mid_r0", 32'(rf_arr[0]), 32'h0000_A300);
        check("rst_mid_r1", 32'(rf_arr[1]), 32'h0000_5551);
        @(posedge clk);
        #1;
        fixed_wait = 0;
        run_op(1'b1, 16'h0010, 8'b0000_0010, 0, lat, wr, req, bsy);
        check("post_rst_lat", 32'(lat), 32'(2));
        check("post_rst_r1", 32'(rf_arr[1]), 32'h0000_A010);

        // Randomized operations with random waits and stray acks
        rand_wait = 1'b1;
        stray_ack = 1'b1;
        for (int n = 0; n < 40; n++) begin
            lm   = 1'($urandom);
            msk  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            base = ($urandom_range(0, 2) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                : 16'($urandom);
            if ($urandom_range(0, 3) == 0) preload(16'($urandom));
            run_op(lm, base, msk, int'($urandom_range(0, 3)), lat, wr, req, bsy);
            check("rand_wr_cnt", 32'(wr), lm ? 32'($countones(msk)) : 32'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
Multi-cycle sequencer for the IITB-RISC load-multiple (LM) and store-multiple (SM) instructions. It sits directly upstream of the 8x16 register file. It walks an 8-bit register mask and performs one data-memory transfer per selected register:
- LM: memory read, then register-file write.
- SM: register-file read, then memory write.

Consecutive memory words are used, starting at a base address. While the sequencer is busy, the core stalls.

Parameters:
DATA_W, 16, data width of registers and memory words
ADDR_W, 16, memory word-address width
NREG, 8, number of architectural registers (mask width)
REG_AW, 3, register address width (log2 NREG)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
is_lm  input  1  1 = load multiple, 0 = store multiple; latched on start
base_addr  input  ADDR_W  first memory word address; latched on start
mask  input  NREG  mask[i]=1 selects register Ri; latched on start
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
mem_req  output  1  memory transfer request
mem_we  output  1  1 = write (SM), 0 = read (LM)
mem_addr  output  ADDR_W  current word address
mem_wdata  output  DATA_W  store data (SM)
mem_rdata  input  DATA_W  load data, valid when mem_ack=1
mem_ack  input  1  transfer complete this cycle
rf_rd_addr  output  REG_AW  register-file read address (SM)
rf_rd_data  input  DATA_W  register-file read data (combinational read)
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  REG_AW  register-file write address
rf_wr_data  output  DATA_W  register-file write data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (asynchronous, any state): state=IDLE and addr_q=0, rem_q=0, lm_q=0. All outputs are 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - On start=1, latch addr_q=base_addr, rem_q=mask, lm_q=is_lm.
  - Next state is XFER if mask!=0, else DONE. A zero mask performs no memory access.
  - start=0: stay in IDLE.
- Register select: idx = index of the lowest set bit of rem_q (priority encoder, R0 first). Registers are transferred in ascending order.
- XFER outputs:
  - mem_req=1, mem_addr=addr_q, mem_we=~lm_q.
  - rf_rd_addr=idx, mem_wdata=rf_rd_data. These are combinational and driven for both LM and SM; mem_wdata is meaningful only for SM.
- XFER, mem_ack=0: hold all state; mem_req and mem_addr remain stable (no retraction).
- XFER, mem_ack=1:
  - LM: rf_wr_en=1, rf_wr_addr=idx, rf_wr_data=mem_rdata, all in the same cycle. The register file captures them at that edge.
  - SM: no register-file write.
  - Clear bit idx of rem_q. Set addr_q=addr_q+1 (modulo 2^ADDR_W; 0xFFFF wraps to 0x0000).
  - If rem_q with idx cleared is zero, go to DONE; else stay in XFER. Back-to-back transfers therefore occur with no bubble.
- rf_wr_en is 0 in every cycle except LM ack cycles. rf_wr_addr and rf_wr_data are 0 when rf_wr_en=0.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 only in IDLE.
- Latency:
  - N selected registers with zero-wait memory (ack in every XFER cycle): start to done = N+1 cycles.
  - Zero mask: done occurs 1 cycle after start.
- start while busy (XFER or DONE): ignored; latched values are unchanged.
- Input changes after start (mask, base_addr, is_lm): no effect on the operation in progress.
- mem_ack outside XFER: ignored.
- Reset asserted mid-transfer: the operation is aborted immediately. No further rf write and no done pulse. A partially completed LM leaves the already-written registers updated.

Decomposition:
- Shared package riscv_pkg:
  - DATA_W, ADDR_W, NREG, REG_AW.
  - State encoding enum seq_state_t {IDLE, XFER, DONE}.
- One sub-module, lowest_set_bit_enc: NREG-bit priority encoder producing the REG_AW index and a valid flag. It is reusable by the decode stage.

Test Plan:
- LM, mask=8'b1000_0101, base=0x0100, zero-wait memory returning 0xA000+addr:
  - Required: R0=0xA100, R2=0xA101, R7=0xA102.
  - Required: rf_wr_en high for 3 cycles; done exactly 4 cycles after start.
- SM, mask=8'hFF, base=0x0020, Ri preloaded with 0x1110+i:
  - Required: writes 0x1110..0x1117 to addresses 0x0020..0x0027 in ascending order.
  - Required: rf_wr_en never high.
- Zero mask: start with mask=0 -> done pulse 1 cycle later; mem_req never asserted; busy high for 1 cycle.
- Wait states and wrap:
  - Stimulus: LM with base=0xFFFF, mask=8'b0000_0011; mem_ack delayed 3 cycles per transfer.
  - Required: mem_addr and mem_req held stable while waiting; addresses 0xFFFF then 0x0000; R0 and R1 written only in ack cycles.
- start pulsed while busy (different mask and base_addr) -> no change to the transfer sequence; the second start is not executed.
- Reset mid-operation: rst_n low during the 2nd transfer of a 4-register LM.
  - Required: outputs 0 immediately; no done pulse.
  - Required: the first register keeps its loaded value; the next start operates normally.
